// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Round-robin pick: first set request at or after the pointer, scanning upward with wrap.
module rr_prio_pick
  import apb_arb_pkg::*;
#(
  parameter int NB_REQ = 2,
  parameter int IDX_W  = idx_width(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  always_comb begin
    int cand;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NB_REQ) cand = cand - NB_REQ;
      // Inner scan keeps every bit select constant after unrolling.
      for (int j = 0; j < NB_REQ; j++) begin
        if (!valid_o && (j == cand) && req_i[j]) begin
          valid_o  = 1'b1;
          idx_o    = IDX_W'(j);
          gnt_o[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB port between NB_REQ requesters: round-robin grant, SETUP/ACCESS
// sequencing and an ACCESS-phase timeout so a hung slave cannot lock the bus.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | bus free; grant and capture a request, may carry rvalid_o
//   ST_SETUP  | PSEL=1, PENABLE=0 for one cycle
//   ST_ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NB_REQ         = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NB_REQ-1:0]                        req_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]    addr_i,
  input  logic [NB_REQ-1:0]                        we_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]    wdata_i,
  output logic [NB_REQ-1:0]                        gnt_o,
  output logic [NB_REQ-1:0]                        rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]                rdata_o,
  output logic                                     err_o,
  output logic [APB_ADDR_WIDTH-1:0]                paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                pwdata_o,
  output logic                                     pwrite_o,
  output logic                                     psel_o,
  output logic                                     penable_o,
  input  logic [APB_DATA_WIDTH-1:0]                prdata_i,
  input  logic                                     pready_i,
  input  logic                                     pslverr_i
);

  localparam int IDX_W = idx_width(NB_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NB_REQ-1:0]         rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [NB_REQ-1:0]         pick_gnt;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_valid;
  logic                      timeout_hit;

  rr_prio_pick #(
    .NB_REQ (NB_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // cnt_q counts completed ACCESS cycles, so the TIMEOUT_CYCLES-th one sees TIMEOUT_CYCLES-1.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    cnt_d    = cnt_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt_o    = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid && !rst_i) begin
          gnt_o    = pick_gnt;
          idx_d    = pick_idx;
          paddr_d  = addr_i[pick_idx];
          pwrite_d = we_i[pick_idx];
          pwdata_d = wdata_i[pick_idx];
          ptr_d    = (pick_idx == IDX_W'(NB_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready_i) begin
          rvalid_d[idx_q] = 1'b1;
          rdata_d         = pwrite_q ? '0 : prdata_i;
          err_d           = pslverr_i;
          cnt_d           = '0;
          state_d         = ST_IDLE;
        end else if (timeout_hit) begin
          rvalid_d[idx_q] = 1'b1;
          rdata_d         = '0;
          err_d           = 1'b1;
          cnt_d           = '0;
          state_d         = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign psel_o    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o = (state_q == ST_ACCESS);
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: vector table plus corner-case sequences,
// completions checked against a scoreboard queue.
module tb_apb_master_arbiter;

  localparam int TO = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0]        req_i;
  logic [1:0][31:0]  addr_i;
  logic [1:0]        we_i;
  logic [1:0][31:0]  wdata_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic [31:0]       rdata_o;
  logic              err_o;
  logic [31:0]       paddr_o;
  logic [31:0]       pwdata_o;
  logic              pwrite_o;
  logic              psel_o;
  logic              penable_o;
  logic [31:0]       prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  apb_master_arbiter #(
    .NB_REQ         (2),
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .pwrite_o  (pwrite_o),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        r;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion monitor: every rvalid pulse must match the oldest expected completion.
  always @(negedge clk_i) begin
    if (rvalid_o != 2'b00) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rvalid", 64'(rvalid_o), 64'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check("rvalid", 64'(rvalid_o), 64'(mon_e.rvalid));
        check("rdata", 64'(rdata_o), 64'(mon_e.rdata));
        check("err", 64'(err_o), 64'(mon_e.err));
        check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit         to;
    bit         granted;
    int         acc;
    logic [1:0] oh;
    exp_t       e;
    to  = (v.waits >= TO);
    acc = to ? TO : v.waits + 1;
    oh  = 2'b01 << v.r;
    if (v.r) begin
      addr_i[1] = v.addr; we_i[1] = v.we; wdata_i[1] = v.wdata;
    end else begin
      addr_i[0] = v.addr; we_i[0] = v.we; wdata_i[0] = v.wdata;
    end
    prdata_i  = v.prdata;
    pslverr_i = v.slverr;
    pready_i  = 1'b0;
    req_i     = oh;
    granted   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (gnt_o != 2'b00) begin
        granted = 1'b1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    check("gnt", 64'(gnt_o), 64'(oh));
    if (!granted) begin
      req_i = 2'b00;
      return;
    end
    e.rvalid = oh;
    e.rdata  = (to || v.we) ? 32'h0 : v.prdata;
    e.err    = to || v.slverr;
    e.cyc    = cyc + 2 + acc;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    req_i = 2'b00;
    @(negedge clk_i);
    check("setup_sel_en", 64'({psel_o, penable_o}), 64'(2'b10));
    check("setup_paddr", 64'(paddr_o), 64'(v.addr));
    check("setup_pwrite", 64'(pwrite_o), 64'(v.we));
    check("setup_pwdata", 64'(pwdata_o), 64'(v.wdata));
    @(posedge clk_i);
    #1;
    for (int w = 0; w < acc; w++) begin
      pready_i = (w == v.waits);
      @(negedge clk_i);
      check("access_sel_en", 64'({psel_o, penable_o}), 64'(2'b11));
      check("access_paddr", 64'(paddr_o), 64'(v.addr));
      @(posedge clk_i);
      #1;
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    @(negedge clk_i);
    check("rsp_sel_en", 64'({psel_o, penable_o}), 64'(2'b00));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   owner;

    vecs[0] = '{r:1'b0, we:1'b1, addr:32'h1A10_1000, wdata:32'hDEAD_BEEF, waits:0, prdata:32'h0BAD_F00D, slverr:1'b0};
    vecs[1] = '{r:1'b1, we:1'b0, addr:32'h1A10_0004, wdata:32'h0000_1111, waits:2, prdata:32'h1234_5678, slverr:1'b0};
    vecs[2] = '{r:1'b0, we:1'b0, addr:32'h1A10_2000, wdata:32'h0000_2222, waits:9, prdata:32'hFFFF_0000, slverr:1'b0};
    vecs[3] = '{r:1'b1, we:1'b0, addr:32'h1A10_3008, wdata:32'h0000_3333, waits:3, prdata:32'h55AA_55AA, slverr:1'b0};
    vecs[4] = '{r:1'b0, we:1'b0, addr:32'h1A10_400C, wdata:32'h0000_4444, waits:0, prdata:32'h0BAD_0001, slverr:1'b1};
    vecs[5] = '{r:1'b1, we:1'b1, addr:32'h1A10_5010, wdata:32'hA5A5_5A5A, waits:1, prdata:32'h7777_7777, slverr:1'b1};
    vecs[6] = '{r:1'b0, we:1'b1, addr:32'h1A10_6014, wdata:32'h0F0F_F0F0, waits:6, prdata:32'h8888_8888, slverr:1'b0};

    rst_i     = 1'b1;
    req_i     = 2'b00;
    addr_i    = '0;
    we_i      = 2'b00;
    wdata_i   = '0;
    prdata_i  = 32'h0;
    pready_i  = 1'b0;
    pslverr_i = 1'b0;

    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_sel_en", 64'({psel_o, penable_o}), 64'(2'b00));
    check("rst_paddr", 64'(paddr_o), 64'(0));
    check("rst_pwdata", 64'(pwdata_o), 64'(0));
    check("rst_pwrite", 64'(pwrite_o), 64'(0));
    check("rst_rvalid", 64'(rvalid_o), 64'(0));
    check("rst_rdata", 64'(rdata_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    check("rst_gnt", 64'(gnt_o), 64'(0));
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      @(posedge clk_i);
      #1;
    end

    // Both requesters held: grants must alternate, one every 3 cycles.
    do_reset();
    addr_i[0] = 32'h1A10_A000;
    addr_i[1] = 32'h1A10_B000;
    we_i      = 2'b00;
    prdata_i  = 32'hCAFE_0001;
    pready_i  = 1'b1;
    req_i     = 2'b11;
    owner     = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (k % 3 == 0) begin
        check("rr_gnt", 64'(gnt_o), 64'(2'b01 << owner));
        e.rvalid = 2'b01 << owner;
        e.rdata  = 32'hCAFE_0001;
        e.err    = 1'b0;
        e.cyc    = cyc + 3;
        sb_q.push_back(e);
        owner = 1 - owner;
      end else begin
        check("rr_busy_gnt", 64'(gnt_o), 64'(0));
      end
      if (k % 3 == 1)
        check("rr_paddr", 64'(paddr_o), 64'((owner == 1) ? 32'h1A10_A000 : 32'h1A10_B000));
      @(posedge clk_i);
      #1;
    end
    req_i = 2'b00;
    @(negedge clk_i);
    pready_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset in the 2nd ACCESS cycle drops the transfer and the pointer.
    prdata_i = 32'h3333_4444;
    req_i    = 2'b01;
    @(negedge clk_i);
    check("rst_seq_gnt", 64'(gnt_o), 64'(2'b01));
    @(posedge clk_i);
    #1;
    req_i = 2'b00;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_seq_access2", 64'({psel_o, penable_o}), 64'(2'b11));
    check("rst_seq_gnt_in_rst", 64'(gnt_o), 64'(0));
    @(posedge clk_i);
    #1;
    req_i = 2'b01;
    @(negedge clk_i);
    check("rst_seq_sel_en", 64'({psel_o, penable_o}), 64'(2'b00));
    check("rst_seq_gnt_forced", 64'(gnt_o), 64'(0));
    check("rst_seq_rvalid", 64'(rvalid_o), 64'(0));
    check("rst_seq_err", 64'(err_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    req_i    = 2'b11;
    pready_i = 1'b1;
    @(negedge clk_i);
    check("rst_seq_ptr0_gnt", 64'(gnt_o), 64'(2'b01));
    e.rvalid = 2'b01;
    e.rdata  = 32'h3333_4444;
    e.err    = 1'b0;
    e.cyc    = cyc + 3;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    req_i = 2'b00;
    repeat (4) @(negedge clk_i);
    pready_i = 1'b0;

    repeat (2) @(negedge clk_i);
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
